// File: rtl/spi_pkg.sv
// Shared constants for the SPI slave link: FSM state encodings and frame geometry.
package spi_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_SHIFT = 2'd3;

    localparam int unsigned SPI_BITS = 8;
    localparam int unsigned CNT_W    = $clog2(SPI_BITS);

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with a history flop
// providing single-cycle rise/fall strobes on the synchronised level.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign fall  = ~sync_q[SYNC_STAGES-1] & hist_q;

endmodule

// File: rtl/spi_slave_link.sv
// SPI mode-0 slave that streams consecutive memory bytes out on MISO during one
// SS frame, driving reset_addr/incr to walk the address, and captures MOSI bytes.
module spi_slave_link
    import spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sck,
    input  logic       spi_ss_n,
    input  logic       spi_mosi,
    input  logic [7:0] tx_byte,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic       reset_addr,
    output logic       incr,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       busy
);

    logic sck_rise, sck_fall, sck_level_unused;
    logic ss_rise, ss_fall, ss_level_unused;
    logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .clk   (clk),
        .rst   (rst),
        .din   (spi_sck),
        .level (sck_level_unused),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
        .clk   (clk),
        .rst   (rst),
        .din   (spi_ss_n),
        .level (ss_level_unused),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk   (clk),
        .rst   (rst),
        .din   (spi_mosi),
        .level (mosi_sync),
        .rise  (mosi_rise_unused),
        .fall  (mosi_fall_unused)
    );

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]       tx_sr_q, tx_sr_d;
    logic [7:0]       rx_sr_q, rx_sr_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             rx_valid_q, rx_valid_d;
    logic             incr_q, incr_d;
    logic             byte_done_q, byte_done_d;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        tx_sr_d     = tx_sr_q;
        rx_sr_d     = rx_sr_q;
        rx_byte_d   = rx_byte_q;
        rx_valid_d  = 1'b0;
        incr_d      = 1'b0;
        byte_done_d = byte_done_q;

        // SS release aborts any state, discarding a partial byte.
        if (ss_rise) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ss_fall) state_d = ST_START;
                end
                ST_START: begin
                    bit_cnt_d   = '0;
                    byte_done_d = 1'b0;
                    state_d     = ST_LOAD;
                end
                ST_LOAD: begin
                    tx_sr_d   = tx_byte;
                    bit_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (sck_rise) begin
                        rx_sr_d   = {rx_sr_q[6:0], mosi_sync};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == CNT_W'(SPI_BITS - 1)) begin
                            rx_byte_d   = {rx_sr_q[6:0], mosi_sync};
                            rx_valid_d  = 1'b1;
                            incr_d      = 1'b1;
                            byte_done_d = 1'b1;
                        end
                    end else if (sck_fall) begin
                        // Falling edge after a byte boundary picks up the byte at the advanced address.
                        if (bit_cnt_q == '0 && byte_done_q) tx_sr_d = tx_byte;
                        else                                 tx_sr_d = {tx_sr_q[6:0], 1'b0};
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            incr_q      <= 1'b0;
            byte_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_sr_q     <= tx_sr_d;
            rx_sr_q     <= rx_sr_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            incr_q      <= incr_d;
            byte_done_q <= byte_done_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign spi_miso_oe = busy;
    assign spi_miso    = busy & tx_sr_q[7];
    assign reset_addr  = (state_q == ST_START);
    assign incr        = incr_q;
    assign rx_byte     = rx_byte_q;
    assign rx_valid    = rx_valid_q;

endmodule

// File: doc/spi_slave_link.md
Name: spi_slave_link

Overview:
- SPI mode-0 slave front end that serves the sensor-capture byte memory to an external SPI master (MCU).
- Synchronises SCK/SS/MOSI into the system clock domain and shifts the current memory byte out on MISO, MSB first.
- Drives the memory's reset_addr/incr controls so successive bytes in one SS frame stream consecutive addresses.
- Also captures MOSI bytes for future command use.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of input synchronisers on spi_sck, spi_ss_n, spi_mosi (min 2).

Ports:
- clk  input  1  system clock; clk frequency >= 8x SCK frequency.
- rst  input  1  synchronous, active-high reset.
- spi_sck  input  1  SPI clock from master, idle low (CPOL=0).
- spi_ss_n  input  1  slave select, active low.
- spi_mosi  input  1  master-out data.
- tx_byte  input  8  byte to transmit, combinational from memory at current address.
- spi_miso  output  1  slave-out data.
- spi_miso_oe  output  1  high while selected; top level tristates MISO when low.
- reset_addr  output  1  one-cycle pulse that rewinds memory address to 0.
- incr  output  1  one-cycle pulse that advances memory address.
- rx_byte  output  8  last complete byte received on MOSI.
- rx_valid  output  1  one-cycle strobe, rx_byte updated.
- busy  output  1  high when state != IDLE.

Behaviour:
- Reset values: spi_miso=0, spi_miso_oe=0, reset_addr=0, incr=0, rx_byte=0, rx_valid=0, busy=0, state=IDLE, bit_cnt=0, shift registers=0.
- Synchronisers: SYNC_STAGES flops per input, plus one history flop per input for edge detection.
  - sck_rise = synced 0->1; sck_fall = synced 1->0.
  - ss_fall and ss_rise are defined the same way on synced SS.
- FSM states: IDLE, START, LOAD, SHIFT.
  - IDLE -> START on ss_fall.
  - START (1 cycle): reset_addr=1.
  - LOAD (1 cycle): memory address is 0; tx_sr <= tx_byte; bit_cnt <= 0; -> SHIFT.
  - SHIFT: remains until ss_rise.
  - Any state -> IDLE on synced spi_ss_n high (ss_rise). Abort takes priority over all other events in the same cycle.
- Master timing requirement: first SCK rising edge no earlier than SYNC_STAGES+4 clk cycles after SS falls.
- spi_miso = tx_sr[7] while not IDLE, else 0. spi_miso_oe = not IDLE.
- In SHIFT, on sck_rise:
  - rx_sr <= {rx_sr[6:0], mosi_sync}; bit_cnt <= bit_cnt+1 (3-bit, wraps 7->0).
  - If bit_cnt==7: rx_byte <= {rx_sr[6:0], mosi_sync}, rx_valid=1 next cycle, incr=1 next cycle (single-cycle pulse).
- In SHIFT, on sck_fall:
  - If bit_cnt==0 and at least one byte has completed in this frame: tx_sr <= tx_byte. incr has settled at least 3 cycles earlier, so tx_byte reflects the new address.
  - Otherwise tx_sr <= {tx_sr[6:0], 1'b0}.
- The first sck_fall of a frame after LOAD, when bit_cnt==0 with no completed byte, shifts normally; bit 7 is already on MISO from LOAD.
- sck_rise and sck_fall cannot coincide (single synced signal).
- SS released mid-byte: partial byte discarded; no rx_valid, no incr; bit_cnt cleared on next START.
- SCK edges while IDLE are ignored.
- Address wrap beyond the memory depth is the memory's concern; this block keeps issuing incr per byte.
- rst asserted mid-frame: immediate return to reset values. Frame resumes only on a fresh ss_fall.

Decomposition:
- Shared package spi_pkg: state encoding constants (ST_IDLE=0, ST_START=1, ST_LOAD=2, ST_SHIFT=3) and SPI_BITS=8.
- Sub-module spi_sync_edge: parameterised synchroniser plus edge detector, outputs level/rise/fall. Instantiated 3x (sck, ss, mosi); mosi uses level only.

Test Plan:
- Reset, then idle with SS high for 20 cycles -> all outputs 0, spi_miso_oe=0.
- SS low, tx_byte model = memory holding 0xA5,0x3C; 8 SCK cycles (SCK period 16 clk) -> reset_addr single pulse, MISO bits 1,0,1,0,0,1,0,1 sampled at rising edges, one incr pulse after 8th rise.
- Continue 8 more SCK in same frame -> MISO shows 0x3C, second incr; MOSI driven 0x5A then 0xC3 -> rx_valid twice with rx_byte 0x5A, 0xC3.
- SS released after 5 bits, then new frame -> no rx_valid/incr in aborted frame; new frame restarts at address 0 (reset_addr pulse, MISO = 0xA5).
- rst asserted for 1 cycle mid-byte -> outputs return to reset values next cycle; SCK edges ignored until next SS fall.
- SCK toggling while SS high -> no incr, no rx_valid, spi_miso_oe=0 throughout.
